inst_fetch_resp: RTL and testbench
==================================

Name: inst_fetch_resp

Overview:
- Responder end of the instruction-fetch interface: accepts fetch requests from the program counter (ce, inst_address) and returns the 32-bit instruction word with a one-cycle valid pulse.
- Issues requests to a word-addressed instruction memory with a ready handshake.
- Holds a one-entry last-fetch buffer so that repeated fetches of the same address do not go to memory.
- Drives stall back to the PC so the PC holds its address until the instruction is delivered.

Parameters:
- ADDR_W, 10, word-index width of instruction memory; byte address bits [ADDR_W+1:2] are used.
- TIMEOUT, 16, maximum cycles waiting for mem_ready before reporting a bus error (valid range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ce  input  1  fetch enable from the PC; when 1, a request is pending at inst_address.
- inst_address  input  32  byte address of the requested instruction.
- inst  output  32  returned instruction word; 32'h00000000 (NOP) on error.
- inst_valid  output  1  one-cycle pulse: inst, addr_err and bus_err are valid.
- stall  output  1  combinational; PC must hold inst_address while this is 1.
- addr_err  output  1  misaligned fetch (inst_address[1:0] != 0); qualified by inst_valid.
- bus_err  output  1  memory timeout; qualified by inst_valid.
- mem_en  output  1  memory request, held until accepted.
- mem_addr  output  ADDR_W  word index sent to memory.
- mem_rdata  input  32  memory read data, valid when mem_ready=1.
- mem_ready  input  1  memory accepts and completes the request in this cycle.

Behaviour:
- Reset (rst=0, async): state=IDLE; inst=0, inst_valid=0, addr_err=0, bus_err=0, mem_en=0, mem_addr=0. Buffer invalid (buf_valid=0, buf_addr=0, buf_data=0). Timeout counter=0.
- stall = ce && (state != RESP).
- IDLE, ce=0:
  - No action.
- IDLE, ce=1: capture req_addr=inst_address, then take the first matching case:
  - misaligned → RESP with addr_err=1, inst=0; memory untouched.
  - buf_valid && buf_addr==inst_address → hit: inst<=buf_data, next state RESP.
  - otherwise → mem_en<=1, mem_addr<=inst_address[ADDR_W+1:2], counter<=0, next state WAIT.
- WAIT:
  - mem_ready=1: inst<=mem_rdata; buf_addr<=req_addr, buf_data<=mem_rdata, buf_valid<=1; mem_en<=0; next state RESP.
  - mem_ready=0: counter increments.
  - counter==TIMEOUT-1 with mem_ready=0: mem_en<=0, bus_err=1, inst=0, buffer unchanged; next state RESP.
  - mem_en and mem_addr are stable throughout WAIT.
- RESP:
  - inst_valid=1 for exactly this cycle, then IDLE.
  - addr_err and bus_err are cleared on the next request capture.
  - inst holds its value until the next update.
- Latency, measured from the ce=1 request cycle T:
  - hit or misaligned: inst_valid at T+1.
  - miss with k wait cycles (mem_ready first high in cycle T+1+k): inst_valid at T+2+k; minimum 2 cycles.
- Back-to-back: the PC advances during RESP (stall=0), so the new request is sampled in the IDLE cycle after RESP. Sustained throughput is 1 instruction per 2 cycles on hits.
- inst_address changing while stall=1 is a PC protocol violation; the block uses req_addr only.
- ce dropping during WAIT: the memory transaction still completes and the buffer is filled, but inst_valid is suppressed in RESP.
- ce dropping at RESP: inst_valid is still asserted.
- Address wrap: bits above ADDR_W+1 are ignored for mem_addr. The buffer tag compares the full 32 bits, so aliased addresses miss and refetch.
- Reset asserted mid-WAIT: mem_en drops immediately (async) and the buffer is invalidated.

Decomposition:
- Shared package (fetch_pkg):
  - state enum {IDLE, WAIT, RESP}.
  - NOP_INST=32'h00000000.
  - ADDR_W default constant.
- Natural sub-module: fetch_line_buf, the one-entry tag/data/valid register with a hit comparator.
  - Inputs: fill and addr/data.
  - Output: hit/data.
  - Has its own async active-low reset.
- FSM, timeout counter and handshake stay in inst_fetch_resp.

Test Plan:
- Reset then miss: rst low→high, ce=1, inst_address=32'h00000010, mem_ready high one cycle after mem_en with mem_rdata=32'h20010005. Expect:
  - mem_addr=4;
  - inst_valid at T+2 with inst=32'h20010005;
  - stall high at T and T+1, low at T+2.
- Buffer hit: repeat 32'h00000010 immediately after the previous test → mem_en stays 0; inst_valid at T+1 with inst=32'h20010005.
- Wait states: address 32'h00000020, mem_ready held low 3 cycles after mem_en → mem_en/mem_addr=8 stable 4 cycles; inst_valid at T+5.
- Misaligned: inst_address=32'h00000006 → addr_err=1, inst=0, inst_valid at T+1, no mem_en.
- Timeout: TIMEOUT=4, mem_ready never asserted → mem_en high 4 cycles, then bus_err=1, inst=0, inst_valid pulse; a following fetch of the same address misses.
- Async reset mid-WAIT: drop rst in WAIT without a clock edge → mem_en=0 and inst_valid=0 immediately; after release, the previously buffered address misses.

Source files
------------

// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package fetch_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/inst_fetch_resp_if.sv
// Word-addressed instruction memory bus with a single-cycle ready handshake.
interface inst_fetch_resp_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/inst_fetch_resp_line_buf.sv
// One-entry last-fetch buffer: full 32-bit tag, data word and valid bit.
module fetch_line_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_data,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] data
);

  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= 32'h0;
      buf_data  <= NOP_INST;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_addr  <= fill_addr;
      buf_data  <= fill_data;
    end
  end

  // Full-width tag so addresses aliasing onto the same word index still miss.
  assign hit  = buf_valid && (buf_addr == lookup_addr);
  assign data = buf_data;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: serves PC fetches from a one-entry buffer or
// from memory, with misalignment and timeout reporting and a stall to the PC.
module inst_fetch_resp
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [31:0]        inst_address,
  output logic [31:0]        inst,
  output logic               inst_valid,
  output logic               stall,
  output logic               addr_err,
  output logic               bus_err,
  inst_fetch_resp_if.master  mem
);

  state_t            state, state_next;
  logic [31:0]       req_addr, req_addr_next;
  logic [31:0]       inst_next;
  logic              addr_err_next, bus_err_next;
  logic              mem_en_q, mem_en_next;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_next;
  logic [7:0]        cnt, cnt_next;
  logic              drop, drop_next;
  logic              fill;
  logic              hit;
  logic [31:0]       buf_data;

  fetch_line_buf u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .fill        (fill),
    .fill_addr   (req_addr),
    .fill_data   (mem.mem_rdata),
    .lookup_addr (inst_address),
    .hit         (hit),
    .data        (buf_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_addr   <= 32'h0;
      inst       <= NOP_INST;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      cnt        <= 8'd0;
      drop       <= 1'b0;
    end else begin
      state      <= state_next;
      req_addr   <= req_addr_next;
      inst       <= inst_next;
      addr_err   <= addr_err_next;
      bus_err    <= bus_err_next;
      mem_en_q   <= mem_en_next;
      mem_addr_q <= mem_addr_next;
      cnt        <= cnt_next;
      drop       <= drop_next;
    end
  end

  always_comb begin
    state_next    = state;
    req_addr_next = req_addr;
    inst_next     = inst;
    addr_err_next = addr_err;
    bus_err_next  = bus_err;
    mem_en_next   = mem_en_q;
    mem_addr_next = mem_addr_q;
    cnt_next      = cnt;
    drop_next     = drop;
    fill          = 1'b0;
    case (state)
      IDLE: begin
        if (ce) begin
          req_addr_next = inst_address;
          addr_err_next = 1'b0;
          bus_err_next  = 1'b0;
          drop_next     = 1'b0;
          if (inst_address[1:0] != 2'b00) begin
            addr_err_next = 1'b1;
            inst_next     = NOP_INST;
            state_next    = RESP;
          end else if (hit) begin
            inst_next  = buf_data;
            state_next = RESP;
          end else begin
            mem_en_next   = 1'b1;
            mem_addr_next = inst_address[ADDR_W+1:2];
            cnt_next      = 8'd0;
            state_next    = WAIT;
          end
        end
      end
      WAIT: begin
        // A PC that gives up mid-transaction still lets memory finish and
        // fills the buffer, but gets no delivery pulse.
        if (!ce) drop_next = 1'b1;
        if (mem.mem_ready) begin
          inst_next   = mem.mem_rdata;
          fill        = 1'b1;
          mem_en_next = 1'b0;
          state_next  = RESP;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          mem_en_next  = 1'b0;
          bus_err_next = 1'b1;
          inst_next    = NOP_INST;
          state_next   = RESP;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign inst_valid   = (state == RESP) && !drop;
  assign stall        = ce && (state != RESP);
  assign mem.mem_en   = mem_en_q;
  assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp with hand-computed expectations (TIMEOUT=4).
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] inst_address = 32'h0;
  logic [31:0] inst;
  logic        inst_valid, stall, addr_err, bus_err;
  int          vectors = 0;
  int          miscompares = 0;

  inst_fetch_resp_if #(.ADDR_W(10)) mem_bus ();

  inst_fetch_resp #(.ADDR_W(10), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .inst_address (inst_address),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .stall        (stall),
    .addr_err     (addr_err),
    .bus_err      (bus_err),
    .mem          (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (inst !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_inst: got %h expected %h", inst, 32'h0); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid); end
    vectors++; if (mem_bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_bus.mem_en); end
    vectors++; if (mem_bus.mem_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %0d expected 0", mem_bus.mem_addr); end
    vectors++; if ({addr_err, bus_err, stall} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected 000", {addr_err, bus_err, stall}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_miss();
    ce = 1'b1; inst_address = 32'h0000_0010;
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_stall_T: got %b expected 1", stall); end
    tick();
    vectors++; if (mem_bus.mem_en !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_mem_en: got %b expected 1", mem_bus.mem_en); end
    vectors++; if (mem_bus.mem_addr !== 10'd4) begin miscompares++; $display("[TB] FAIL miss_mem_addr: got %0d expected 4", mem_bus.mem_addr); end
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_stall_T1: got %b expected 1", stall); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_valid_T1: got %b expected 0", inst_valid); end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h2001_0005;
    tick();
    mem_bus.mem_ready = 1'b0;
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_valid_T2: got %b expected 1", inst_valid); end
    vectors++; if (inst !== 32'h2001_0005) begin miscompares++; $display("[TB] FAIL miss_inst: got %h expected %h", inst, 32'h2001_0005); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_stall_T2: got %b expected 0", stall); end
    vectors++; if (mem_bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_mem_en_T2: got %b expected 0", mem_bus.mem_en); end
    tick();
  endtask

  task automatic test_hit();
    #1;
    vectors++; if (mem_bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_mem_en_T: got %b expected 0", mem_bus.mem_en); end
    tick();
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hit_valid: got %b expected 1", inst_valid); end
    vectors++; if (inst !== 32'h2001_0005) begin miscompares++; $display("[TB] FAIL hit_inst: got %h expected %h", inst, 32'h2001_0005); end
    vectors++; if (mem_bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_mem_en: got %b expected 0", mem_bus.mem_en); end
    ce = 1'b0;
    tick();
  endtask

  task automatic test_alias();
    ce = 1'b1; inst_address = 32'h0000_1010;
    tick();
    vectors++; if (mem_bus.mem_en !== 1'b1) begin miscompares++; $display("[TB] FAIL alias_mem_en: got %b expected 1", mem_bus.mem_en); end
    vectors++; if (mem_bus.mem_addr !== 10'd4) begin miscompares++; $display("[TB] FAIL alias_mem_addr: got %0d expected 4", mem_bus.mem_addr); end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_bus.mem_ready = 1'b0;
    vectors++; if (inst !== 32'h0BAD_F00D || inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL alias_resp: got %h/%b expected %h/1", inst, inst_valid, 32'h0BAD_F00D); end
    ce = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    ce = 1'b1; inst_address = 32'h0000_0020;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 10'd8) begin miscompares++; $display("[TB] FAIL wait_bus_c%0d: got %b/%0d expected 1/8", c, mem_bus.mem_en, mem_bus.mem_addr); end
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wait_valid_c%0d: got %b expected 0", c, inst_valid); end
      if (c == 4) begin mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF; end
    end
    tick();
    mem_bus.mem_ready = 1'b0;
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wait_valid_T5: got %b expected 1", inst_valid); end
    vectors++; if (inst !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wait_inst: got %h expected %h", inst, 32'hDEAD_BEEF); end
    ce = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    ce = 1'b1; inst_address = 32'h0000_0006;
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_stall: got %b expected 1", stall); end
    tick();
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_valid: got %b expected 1", inst_valid); end
    vectors++; if (addr_err !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_addr_err: got %b expected 1", addr_err); end
    vectors++; if (inst !== 32'h0) begin miscompares++; $display("[TB] FAIL mis_inst: got %h expected %h", inst, 32'h0); end
    vectors++; if (mem_bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_mem_en: got %b expected 0", mem_bus.mem_en); end
    ce = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    ce = 1'b1; inst_address = 32'h0000_0040;
    tick();
    vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_addr_err_clear: got %b expected 0", addr_err); end
    for (int c = 1; c <= 4; c++) begin
      vectors++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 10'd16) begin miscompares++; $display("[TB] FAIL to_bus_c%0d: got %b/%0d expected 1/16", c, mem_bus.mem_en, mem_bus.mem_addr); end
      tick();
    end
    vectors++; if (inst_valid !== 1'b1 || bus_err !== 1'b1) begin miscompares++; $display("[TB] FAIL to_resp: got valid %b bus_err %b expected 1 1", inst_valid, bus_err); end
    vectors++; if (inst !== 32'h0) begin miscompares++; $display("[TB] FAIL to_inst: got %h expected %h", inst, 32'h0); end
    vectors++; if (mem_bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL to_mem_en_drop: got %b expected 0", mem_bus.mem_en); end
    tick();
    tick();
    vectors++; if (mem_bus.mem_en !== 1'b1) begin miscompares++; $display("[TB] FAIL to_refetch_miss: got %b expected 1", mem_bus.mem_en); end
    vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_bus_err_clear: got %b expected 0", bus_err); end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
    tick();
    mem_bus.mem_ready = 1'b0;
    vectors++; if (inst !== 32'h1111_2222 || inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL to_refetch_resp: got %h/%b expected %h/1", inst, inst_valid, 32'h1111_2222); end
    ce = 1'b0;
    tick();
  endtask

  task automatic test_ce_drop();
    ce = 1'b1; inst_address = 32'h0000_0100;
    tick();
    ce = 1'b0; mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hCAFE_0001;
    tick();
    mem_bus.mem_ready = 1'b0;
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_valid: got %b expected 0", inst_valid); end
    tick();
    ce = 1'b1;
    tick();
    vectors++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001) begin miscompares++; $display("[TB] FAIL drop_buffer_hit: got %b/%h expected 1/%h", inst_valid, inst, 32'hCAFE_0001); end
    ce = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    ce = 1'b1; inst_address = 32'h0000_0080;
    tick();
    vectors++; if (mem_bus.mem_en !== 1'b1) begin miscompares++; $display("[TB] FAIL ar_wait_mem_en: got %b expected 1", mem_bus.mem_en); end
    rst = 1'b0;
    #1;
    vectors++; if (mem_bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_mem_en: got %b expected 0", mem_bus.mem_en); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_valid: got %b expected 0", inst_valid); end
    ce = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);
    ce = 1'b1; inst_address = 32'h0000_0100;
    tick();
    vectors++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 10'd64) begin miscompares++; $display("[TB] FAIL ar_refetch_miss: got %b/%0d expected 1/64", mem_bus.mem_en, mem_bus.mem_addr); end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h5555_AAAA;
    tick();
    mem_bus.mem_ready = 1'b0;
    vectors++; if (inst !== 32'h5555_AAAA || inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ar_refetch_resp: got %h/%b expected %h/1", inst, inst_valid, 32'h5555_AAAA); end
    ce = 1'b0;
    tick();
  endtask

  initial begin
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    test_reset();
    test_miss();
    test_hit();
    test_alias();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_ce_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
